// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// pointer-based register writes and auto-incrementing reads.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         AW          = 2,
   parameter int         SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          sda_oe,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_p, sda_p;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_t        state, state_n;
   logic [7:0]    shift, shift_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic          ack_phase, ack_phase_n;
   logic [AW-1:0] ptr, ptr_n;
   logic          rw, rw_n;
   logic          nack, nack_n;
   logic          first_byte, first_n;
   logic          sda_oe_n, busy_n, wr_en_n;
   logic [AW-1:0] wr_addr_n;
   logic [7:0]    wr_data_n;
   logic [7:0]    rx_byte;

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_p;
   assign scl_fall  = ~scl_s & scl_p;
   assign start_det = scl_s & scl_p & sda_p & ~sda_s;
   assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
   assign rx_byte   = {shift[6:0], sda_s};
   assign rd_addr   = ptr;

   // Synchronizers preset high so a reset looks like an idle bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_p    <= scl_s;
         sda_p    <= sda_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         ack_phase  <= 1'b0;
         ptr        <= '0;
         rw         <= 1'b0;
         nack       <= 1'b0;
         first_byte <= 1'b0;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         state      <= state_n;
         shift      <= shift_n;
         bit_cnt    <= bit_cnt_n;
         ack_phase  <= ack_phase_n;
         ptr        <= ptr_n;
         rw         <= rw_n;
         nack       <= nack_n;
         first_byte <= first_n;
         sda_oe     <= sda_oe_n;
         busy       <= busy_n;
         wr_en      <= wr_en_n;
         wr_addr    <= wr_addr_n;
         wr_data    <= wr_data_n;
      end
   end

   // ack_phase marks "9th rise seen" in ACK states and "8 bits sent" in RD_BYTE.
   always_comb begin
      state_n     = state;
      shift_n     = shift;
      bit_cnt_n   = bit_cnt;
      ack_phase_n = ack_phase;
      ptr_n       = ptr;
      rw_n        = rw;
      nack_n      = nack;
      first_n     = first_byte;
      sda_oe_n    = sda_oe;
      busy_n      = busy;
      wr_en_n     = 1'b0;
      wr_addr_n   = wr_addr;
      wr_data_n   = wr_data;

      if (start_det || stop_det) begin
         state_n     = start_det ? ADDR : IDLE;
         bit_cnt_n   = '0;
         ack_phase_n = 1'b0;
         sda_oe_n    = 1'b0;
         busy_n      = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) begin
                  shift_n   = rx_byte;
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ack_phase_n = 1'b0;
                     if (shift[6:0] == SLAVE_ADDR) begin
                        state_n = ADDR_ACK;
                        busy_n  = 1'b1;
                        rw_n    = sda_s;
                     end else begin
                        state_n = IGNORE;
                     end
                  end
               end
            end
            ADDR_ACK, WR_ACK: begin
               if (scl_rise) begin
                  ack_phase_n = 1'b1;
               end else if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe_n = 1'b1;
                  end else begin
                     ack_phase_n = 1'b0;
                     bit_cnt_n   = '0;
                     if (state == WR_ACK || !rw) begin
                        sda_oe_n = 1'b0;
                        state_n  = WR_BYTE;
                        if (state == ADDR_ACK) first_n = 1'b1;
                     end else begin
                        shift_n  = rd_data;
                        sda_oe_n = ~rd_data[7];
                        state_n  = RD_BYTE;
                     end
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shift_n   = rx_byte;
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (first_byte) begin
                        ptr_n   = rx_byte[AW-1:0];
                        first_n = 1'b0;
                     end else begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = ptr;
                        wr_data_n = rx_byte;
                        ptr_n     = ptr + PTR_ONE;
                     end
                     ack_phase_n = 1'b0;
                     state_n     = WR_ACK;
                  end
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) ack_phase_n = 1'b1;
               end else if (scl_fall) begin
                  if (ack_phase) begin
                     sda_oe_n    = 1'b0;
                     ack_phase_n = 1'b0;
                     state_n     = RD_ACK;
                  end else begin
                     shift_n  = {shift[6:0], 1'b0};
                     sda_oe_n = ~shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  nack_n      = sda_s;
                  ptr_n       = ptr + PTR_ONE;
                  ack_phase_n = 1'b1;
               end else if (scl_fall && ack_phase) begin
                  ack_phase_n = 1'b0;
                  bit_cnt_n   = '0;
                  if (nack) begin
                     state_n = IGNORE;
                  end else begin
                     shift_n  = rd_data;
                     sda_oe_n = ~rd_data[7];
                     state_n  = RD_BYTE;
                  end
               end
            end
            IGNORE: sda_oe_n = 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; writes and read bytes are checked
// against expectations queued as the stimulus is issued.
module tb_i2c_slave;

   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_oe, wr_en, busy;
   logic [1:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;
   wire        sda_bus = m_sda & ~sda_oe;

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];
   logic [7:0] exp_rd[$];

   assign rd_data = {6'h0, rd_addr};

   i2c_slave #(.SLAVE_ADDR(7'h50), .AW(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_bus),
      .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Every clock with wr_en high is one observed write event.
   always @(posedge clk) begin
      #1;
      if (wr_en === 1'b1) obs_q.push_back({wr_addr, wr_data});
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; m_scl = 1'b1; wait_q();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic bus_rstart();
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b1; wait_q();
      m_sda = 1'b1; wait_q();
      wait_q();
   endtask

   task automatic write_bit(input logic b);
      m_sda = b; wait_q();
      m_scl = 1'b1; wait_q(); wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
      b = sda_bus; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack_n);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(ack_n);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic nack);
      logic bit_v;
      for (int i = 7; i >= 0; i--) begin
         read_bit(bit_v);
         b[i] = bit_v;
      end
      write_bit(nack);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({sda_oe, wr_en, busy, wr_addr, rd_addr, wr_data} !== 15'h0) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: got oe=%b wr_en=%b busy=%b wa=%0d ra=%0d wd=%h, required all 0",
                  sda_oe, wr_en, busy, wr_addr, rd_addr, wr_data);
      end
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write();
      logic a;
      bus_start();
      write_byte(8'hA0, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_addr_ack: got %b, required 0", a); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL wr_busy: got %b, required 1", busy); end
      write_byte(8'h01, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_ptr_ack: got %b, required 0", a); end
      exp_q.push_back({2'd1, 8'hA5});
      write_byte(8'hA5, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_d0_ack: got %b, required 0", a); end
      exp_q.push_back({2'd2, 8'h3C});
      write_byte(8'h3C, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_d1_ack: got %b, required 0", a); end
      bus_stop();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_busy_stop: got %b, required 0", busy); end
      while (exp_q.size() > 0) begin
         logic [9:0] e, o;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL wr_event: got none, required addr=%0d data=%h", e[9:8], e[7:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("[TB] FAIL wr_event: got addr=%0d data=%h, required addr=%0d data=%h",
                        o[9:8], o[7:0], e[9:8], e[7:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL wr_extra: got %0d extra writes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_no_match();
      logic a;
      bus_start();
      write_byte(8'hA2, a);
      n_cmp++;
      if (a !== 1'b1) begin n_bad++; $display("[TB] FAIL nm_addr_ack: got %b, required 1", a); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL nm_busy: got %b, required 0", busy); end
      write_byte(8'h01, a);
      n_cmp++;
      if (a !== 1'b1) begin n_bad++; $display("[TB] FAIL nm_ptr_ack: got %b, required 1", a); end
      write_byte(8'hA5, a);
      n_cmp++;
      if (a !== 1'b1) begin n_bad++; $display("[TB] FAIL nm_data_ack: got %b, required 1", a); end
      bus_stop();
      n_cmp++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL nm_side_effects: got %0d writes busy=%b, required 0 writes busy=0",
                  obs_q.size(), busy);
         obs_q.delete();
      end
   endtask

   task automatic test_read();
      logic a;
      logic [7:0] b, e;
      bus_start();
      write_byte(8'hA0, a);
      write_byte(8'h03, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_ptr_ack: got %b, required 0", a); end
      bus_rstart();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_busy_rstart: got %b, required 0", busy); end
      write_byte(8'hA1, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_addr_ack: got %b, required 0", a); end
      exp_rd.push_back(8'h03);
      exp_rd.push_back(8'h00);
      exp_rd.push_back(8'h01);
      for (int k = 0; k < 3; k++) begin
         read_byte(b, (k == 2));
         e = exp_rd.pop_front();
         n_cmp++;
         if (b !== e) begin
            n_bad++;
            $display("[TB] FAIL rd_byte%0d: got %h, required %h", k, b, e);
         end
      end
      repeat (6) @(negedge clk);
      n_cmp++;
      if (sda_oe !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_release: got oe=%b, required 0", sda_oe); end
      n_cmp++;
      if (rd_addr !== 2'd2) begin n_bad++; $display("[TB] FAIL rd_ptr_after: got %0d, required 2", rd_addr); end
      bus_stop();
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL rd_no_write: got %0d writes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_wrap();
      logic a;
      logic [7:0] data_v [5];
      data_v = '{8'hFF, 8'h00, 8'h11, 8'h22, 8'h33};
      bus_start();
      write_byte(8'hA0, a);
      write_byte(8'h00, a);
      for (int k = 0; k < 5; k++) begin
         logic [1:0] addr_v;
         addr_v = 2'(k);
         exp_q.push_back({addr_v, data_v[k]});
         write_byte(data_v[k], a);
      end
      bus_stop();
      while (exp_q.size() > 0) begin
         logic [9:0] e, o;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL wrap_event: got none, required addr=%0d data=%h", e[9:8], e[7:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("[TB] FAIL wrap_event: got addr=%0d data=%h, required addr=%0d data=%h",
                        o[9:8], o[7:0], e[9:8], e[7:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL wrap_extra: got %0d extra writes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      logic a, bit_v;
      logic [7:0] addr_byte;
      addr_byte = 8'hA0;
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
      n_cmp++;
      if (sda_oe !== 1'b1) begin n_bad++; $display("[TB] FAIL rm_ack_driven: got %b, required 1", sda_oe); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (sda_oe !== 1'b0) begin n_bad++; $display("[TB] FAIL rm_ack_release: got %b, required 0", sda_oe); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      bus_stop();
      bus_start();
      write_byte(8'hA1, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL rm_rd_addr_ack: got %b, required 0", a); end
      read_bit(bit_v);
      read_bit(bit_v);
      n_cmp++;
      if (sda_oe !== 1'b1) begin n_bad++; $display("[TB] FAIL rm_bit_driven: got %b, required 1", sda_oe); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (sda_oe !== 1'b0 || wr_en !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL rm_bit_release: got oe=%b wr_en=%b, required 0 0", sda_oe, wr_en);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      bus_stop();
      bus_start();
      write_byte(8'hA0, a);
      n_cmp++;
      if (a !== 1'b0) begin n_bad++; $display("[TB] FAIL rm_after_ack: got %b, required 0", a); end
      bus_stop();
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL rm_no_write: got %0d writes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_stop_midbyte();
      logic a;
      logic [7:0] part;
      part = 8'hC5;
      bus_start();
      write_byte(8'hA0, a);
      write_byte(8'h02, a);
      for (int i = 7; i >= 4; i--) write_bit(part[i]);
      bus_stop();
      n_cmp++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL sm_after_stop: got %0d writes busy=%b, required 0 writes busy=0",
                  obs_q.size(), busy);
         obs_q.delete();
      end
      bus_start();
      write_byte(8'hA0, a);
      write_byte(8'h01, a);
      exp_q.push_back({2'd1, 8'h77});
      write_byte(8'h77, a);
      bus_stop();
      while (exp_q.size() > 0) begin
         logic [9:0] e, o;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL sm_event: got none, required addr=%0d data=%h", e[9:8], e[7:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("[TB] FAIL sm_event: got addr=%0d data=%h, required addr=%0d data=%h",
                        o[9:8], o[7:0], e[9:8], e[7:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL sm_extra: got %0d extra writes, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_no_match();
      test_read();
      test_wrap();
      test_reset_mid();
      test_stop_midbyte();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
